pll_lock_sequencer: RTL and testbench

- Power-up and recovery controller for the main clock PLL; runs on the PLL reference clock (50 MHz board clock), which is always alive.
- Pulses the PLL reset, waits for lock, requires lock to stay stable, then releases the core system reset.
- On lock loss or a software relock request, re-sequences the PLL. After repeated lock timeouts it enters a latched fail state.

---
 rtl/pll_seq_pkg.sv | 21 ++
 rtl/sync2.sv | 26 ++
 rtl/pll_lock_sequencer.sv | 142 ++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and 50 MHz default timing for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    localparam int RETRY_W = 3;

    // Defaults sized for a 50 MHz reference clock.
    localparam int DEF_RST_PULSE_CYC    = 32;
    localparam int DEF_LOCK_STABLE_CYC  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYC = 500000;
    localparam int DEF_MAX_RETRIES      = 4;
    localparam int DEF_CNT_W            = 20;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous single-bit status inputs.
module sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // NOTE: non-blocking assignments make both flops sample on the same edge;
    // blocking here would collapse the chain into a single flop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset, lock qualification and core reset release, with retry and latched fail.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int MAX_RETRIES      = DEF_MAX_RETRIES,
    parameter int CNT_W            = DEF_CNT_W
) (
    input  logic               i_refclk,
    input  logic               i_rst,
    input  logic               i_pll_locked,
    input  logic               i_relock_req,
    output logic               o_pll_rst,
    output logic               o_sys_rst,
    output logic               o_ready,
    output logic               o_fail,
    output logic               o_relock_ack,
    output logic [RETRY_W-1:0] o_retry_cnt
);

    localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [RETRY_W-1:0] r_retry_cnt;
    logic [RETRY_W-1:0] w_retry_nxt;
    logic               w_ack_nxt;
    logic               w_lock_s;
    logic               r_pll_rst;
    logic               r_sys_rst;
    logic               r_ready;
    logic               r_fail;
    logic               r_relock_ack;

    sync2 u_lock_sync (
        .i_clk (i_refclk),
        .i_rst (i_rst),
        .i_d   (i_pll_locked),
        .o_q   (w_lock_s)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_retry_nxt = r_retry_cnt;
        w_ack_nxt   = 1'b0;
        case (r_state)
            RESET_PLL: begin
                if (r_cnt == PULSE_LAST) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_nxt = STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_retry_cnt == RETRY_MAX) begin
                        w_state_nxt = FAIL;
                    end else begin
                        w_state_nxt = RESET_PLL;
                        w_retry_nxt = r_retry_cnt + 1'b1;
                    end
                end
            end
            STABLE: begin
                // A lock dropout restarts the timeout but keeps the retry budget.
                if (!w_lock_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                    w_retry_nxt = '0;
                end
            end
            RUN: begin
                w_cnt_nxt = '0;
                w_ack_nxt = i_relock_req;
                if (!w_lock_s || i_relock_req) begin
                    w_state_nxt = RESET_PLL;
                    w_retry_nxt = '0;
                end
            end
            FAIL: begin
                w_cnt_nxt = '0;
                if (i_relock_req) begin
                    w_state_nxt = RESET_PLL;
                    w_retry_nxt = '0;
                    w_ack_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = RESET_PLL;
                w_cnt_nxt   = '0;
                w_retry_nxt = '0;
            end
        endcase
    end

    // Outputs decode the next state so they switch on the same edge as r_state.
    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_state      <= RESET_PLL;
            r_cnt        <= '0;
            r_retry_cnt  <= '0;
            r_pll_rst    <= 1'b1;
            r_sys_rst    <= 1'b1;
            r_ready      <= 1'b0;
            r_fail       <= 1'b0;
            r_relock_ack <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_retry_cnt  <= w_retry_nxt;
            r_pll_rst    <= (w_state_nxt == RESET_PLL) || (w_state_nxt == FAIL);
            r_sys_rst    <= (w_state_nxt != RUN);
            r_ready      <= (w_state_nxt == RUN);
            r_fail       <= (w_state_nxt == FAIL);
            r_relock_ack <= w_ack_nxt;
        end
    end

    assign o_pll_rst    = r_pll_rst;
    assign o_sys_rst    = r_sys_rst;
    assign o_ready      = r_ready;
    assign o_fail       = r_fail;
    assign o_relock_ack = r_relock_ack;
    assign o_retry_cnt  = r_retry_cnt;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed cycle-accurate bench for pll_lock_sequencer with shortened timing constants.
module tb_pll_lock_sequencer;
    import pll_seq_pkg::*;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic       relock_ack;
    logic [2:0] retry_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .RST_PULSE_CYC    (4),
        .LOCK_STABLE_CYC  (8),
        .LOCK_TIMEOUT_CYC (16),
        .MAX_RETRIES      (2),
        .CNT_W            (20)
    ) dut (
        .i_refclk     (clk),
        .i_rst        (rst),
        .i_pll_locked (pll_locked),
        .i_relock_req (relock_req),
        .o_pll_rst    (pll_rst),
        .o_sys_rst    (sys_rst),
        .o_ready      (ready),
        .o_fail       (fail),
        .o_relock_ack (relock_ack),
        .o_retry_cnt  (retry_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_cycle(input string tag, input state_t e_state, input logic e_pll,
                               input logic e_sys, input logic e_rdy, input logic e_fail,
                               input logic e_ack, input logic [2:0] e_retry);
        check({tag, " state"},   32'(dut.r_state), 32'(e_state));
        check({tag, " pll_rst"}, 32'(pll_rst),     32'(e_pll));
        check({tag, " sys_rst"}, 32'(sys_rst),     32'(e_sys));
        check({tag, " ready"},   32'(ready),       32'(e_rdy));
        check({tag, " fail"},    32'(fail),        32'(e_fail));
        check({tag, " ack"},     32'(relock_ack),  32'(e_ack));
        check({tag, " retry"},   32'(retry_cnt),   32'(e_retry));
    endtask

    // Advance one clock and sample 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        state_t es;

        // Reset values while rst is held.
        step(); step(); step();
        check_cycle("reset", RESET_PLL, 1, 1, 0, 0, 0, 0);
        check("reset cnt", 32'(dut.r_cnt), 32'd0);

        // Power-up: cycle 0 is the first cycle with rst low; lock from cycle 10.
        rst = 1'b0;
        for (int c = 0; c <= 21; c++) begin
            es = (c < 4) ? RESET_PLL : (c < 13) ? WAIT_LOCK : (c < 21) ? STABLE : RUN;
            check_cycle($sformatf("pwr c%0d", c), es, c < 4, c < 21, c >= 21, 0, 0, 0);
            if (c == 10) pll_locked = 1'b1;
            step();
        end

        // Relock request in RUN, then a 3-cycle lock glitch during STABLE.
        relock_req = 1'b1;
        step();
        relock_req = 1'b0;
        for (int c = 0; c <= 21; c++) begin
            es = (c < 4)  ? RESET_PLL : (c < 5)  ? WAIT_LOCK : (c < 10) ? STABLE :
                 (c < 13) ? WAIT_LOCK : (c < 21) ? STABLE    : RUN;
            check_cycle($sformatf("glitch c%0d", c), es, c < 4, c < 21, c >= 21, 0, c == 0, 0);
            if (c == 13) check("glitch stable restart cnt", 32'(dut.r_cnt), 32'd0);
            if (c == 7)  pll_locked = 1'b0;
            if (c == 10) pll_locked = 1'b1;
            step();
        end

        // Lock loss in RUN at t: outputs react at t+3, then a full re-sequence.
        pll_locked = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_cycle($sformatf("loss t+%0d", k), RUN, 0, 0, 1, 0, 0, 0);
            step();
        end
        for (int c = 0; c <= 17; c++) begin
            es = (c < 4) ? RESET_PLL : (c < 9) ? WAIT_LOCK : (c < 17) ? STABLE : RUN;
            check_cycle($sformatf("reseq c%0d", c), es, c < 4, c < 17, c >= 17, 0, 0, 0);
            if (c == 6) pll_locked = 1'b1;
            step();
        end

        // Lock never returns: three pulses, two retries, then FAIL.
        // relock_req is raised during WAIT_LOCK and must be ignored.
        pll_locked = 1'b0;
        for (int k = 0; k < 3; k++) step();
        for (int c = 0; c <= 69; c++) begin
            es = (c < 4)  ? RESET_PLL : (c < 20) ? WAIT_LOCK : (c < 24) ? RESET_PLL :
                 (c < 40) ? WAIT_LOCK : (c < 44) ? RESET_PLL : (c < 60) ? WAIT_LOCK : FAIL;
            check_cycle($sformatf("timeout c%0d", c), es,
                        (c < 4) || (c >= 20 && c < 24) || (c >= 40 && c < 44) || (c >= 60),
                        1, 0, c >= 60, 0,
                        (c < 20) ? 3'd0 : (c < 40) ? 3'd1 : 3'd2);
            if (c == 8)  relock_req = 1'b1;
            if (c == 12) relock_req = 1'b0;
            step();
        end

        // Relock out of FAIL, then rst mid-WAIT_LOCK with cnt=9 and retry_cnt=1.
        relock_req = 1'b1;
        step();
        relock_req = 1'b0;
        for (int c = 0; c <= 38; c++) begin
            es = (c < 4)  ? RESET_PLL : (c < 20) ? WAIT_LOCK : (c < 24) ? RESET_PLL :
                 (c < 34) ? WAIT_LOCK : (c < 38) ? RESET_PLL : WAIT_LOCK;
            check_cycle($sformatf("rstmid c%0d", c), es,
                        (c < 4) || (c >= 20 && c < 24) || (c >= 34 && c < 38),
                        1, 0, 0, c == 0,
                        (c >= 20 && c < 34) ? 3'd1 : 3'd0);
            if (c == 33) check("rstmid pre cnt", 32'(dut.r_cnt), 32'd9);
            if (c == 34) check("rstmid post cnt", 32'(dut.r_cnt), 32'd0);
            if (c == 33) rst = 1'b1;
            if (c == 34) rst = 1'b0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
